// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: combinational RV32I decode plus an IDLE/RUN/DONE
// sequencer that stalls the pipeline around multi-cycle RV32M operations.
module alu_ctrl_seq #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter bit MD_EN   = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            flush,
  input  logic [2:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic            rs2_zero,
  output logic [OP_W-1:0] operation,
  output logic            md_start,
  output logic [2:0]      md_op,
  output logic            md_done,
  output logic            stall,
  output logic            illegal,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_BEQ = 5'd10, OP_BNE = 5'd11;
  localparam logic [4:0] OP_BLT = 5'd12, OP_BGE = 5'd13, OP_BLTU = 5'd14, OP_BGEU = 5'd15;
  localparam logic [4:0] OP_PASSB = 5'd16, OP_MD = 5'd17;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    code;
  logic          bad;
  logic          accept;

  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  endfunction

  always_comb begin
    code = OP_ADD;
    bad  = 1'b0;
    case (alu_op)
      3'b000: code = OP_ADD;
      3'b100: code = OP_PASSB;
      3'b001: begin
        case (funct3)
          3'b000:  code = OP_BEQ;
          3'b001:  code = OP_BNE;
          3'b100:  code = OP_BLT;
          3'b101:  code = OP_BGE;
          3'b110:  code = OP_BLTU;
          3'b111:  code = OP_BGEU;
          default: bad  = 1'b1;
        endcase
      end
      3'b010: begin
        if (funct7 == F7_BASE) code = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) code = OP_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) code = OP_SRA;
        else if (funct7 == F7_MD && MD_EN) code = OP_MD;
        else bad = 1'b1;
      end
      3'b011: begin
        // Immediate forms: funct7 only qualifies the shift encodings.
        code = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) bad = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) code = OP_SRA;
          else if (funct7 != F7_BASE) bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) code = OP_ADD;
  end

  assign illegal   = valid_i & bad;
  assign accept    = (state == IDLE) & valid_i & ~flush & ~bad & (code == OP_MD);
  assign stall     = accept | (state == RUN);
  assign operation = (state != IDLE) ? OP_W'(OP_MD) : OP_W'(code);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      md_op    <= 3'b000;
      md_start <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      md_start <= 1'b0;
      md_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            md_op    <= funct3;
            md_start <= 1'b1;
            state    <= RUN;
            if (funct3[2] && rs2_zero) cnt <= '0;
            else if (funct3[2])        cnt <= DIV_LOAD;
            else                       cnt <= MUL_LOAD;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state   <= DONE;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: table-driven decode model and latency arithmetic
// for the mul/div sequencer, with an expected queue of md_op values.
module tb_alu_ctrl_seq;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i, valid2, flush, rs2_zero;
  logic [2:0] alu_op, funct3;
  logic [6:0] funct7;
  logic [4:0] operation, operation2;
  logic       md_start, md_done, stall, illegal;
  logic       md_start2, md_done2, stall2, illegal2;
  logic [2:0] md_op, md_op2;
  logic [1:0] fsm_state, fsm_state2;

  int tests = 0;
  int fails = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  alu_ctrl_seq #(.OP_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MD_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush(flush), .alu_op(alu_op),
    .funct7(funct7), .funct3(funct3), .rs2_zero(rs2_zero), .operation(operation),
    .md_start(md_start), .md_op(md_op), .md_done(md_done), .stall(stall),
    .illegal(illegal), .fsm_state(fsm_state));

  alu_ctrl_seq #(.OP_W(5), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .MD_EN(1'b0)) u_nomd (
    .clk(clk), .reset(reset), .valid_i(valid2), .flush(flush), .alu_op(alu_op),
    .funct7(funct7), .funct3(funct3), .rs2_zero(rs2_zero), .operation(operation2),
    .md_start(md_start2), .md_op(md_op2), .md_done(md_done2), .stall(stall2),
    .illegal(illegal2), .fsm_state(fsm_state2));

  // Reference decode from the instruction tables.
  function automatic void ref_decode(input logic [2:0] aop, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit md_en,
                                     output int code, output bit bad);
    int alu_tab[8];
    int br_tab[8];
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    br_tab  = '{10, 11, -1, -1, 12, 13, 14, 15};
    code = 0;
    bad  = 1'b0;
    if (aop == 3'd0) code = 0;
    else if (aop == 3'd4) code = 16;
    else if (aop == 3'd1) begin
      code = br_tab[f3];
      bad  = (code < 0);
    end else if (aop == 3'd2) begin
      if (f7 == 7'h00) code = alu_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) code = 1;
      else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
      else if (f7 == 7'h01 && md_en) code = 17;
      else bad = 1'b1;
    end else if (aop == 3'd3) begin
      code = alu_tab[f3];
      if (f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
      if (f3 == 3'd5) begin
        if (f7 == 7'h20) code = 7;
        else if (f7 != 7'h00) bad = 1'b1;
      end
    end else bad = 1'b1;
    if (bad) code = 0;
  endfunction

  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b1; valid2 = 1'b0; flush = 1'b0;
    alu_op = 3'b010; funct7 = 7'h01; funct3 = 3'b000; rs2_zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (fsm_state !== 2'd0 || md_start !== 1'b0 || md_done !== 1'b0 || md_op !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: state=%0d start=%0b done=%0b md_op=%0d, want 0/0/0/0",
               fsm_state, md_start, md_done, md_op);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #2;
    tests++;
    if (md_start !== 1'b1 || fsm_state === 2'd0) begin
      fails++;
      $display("FAIL reset_release_accept: start=%0b state=%0d, want start=1 not idle", md_start, fsm_state);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid_i = 1'b0;
    #1;
    tests++;
    if (fsm_state !== 2'd0 || md_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: state=%0d done=%0b, want 0/0", fsm_state, md_done);
    end
  endtask

  task automatic test_decode();
    logic [2:0] d_aop[5] = '{3'b010, 3'b011, 3'b011, 3'b001, 3'b001};
    logic [6:0] d_f7[5]  = '{7'h20, 7'h20, 7'h01, 7'h55, 7'h00};
    logic [2:0] d_f3[5]  = '{3'b000, 3'b101, 3'b000, 3'b110, 3'b010};
    logic [6:0] f7_pick[4];
    int code, code2;
    bit bad, bad2;
    flush = 1'b1;
    for (int i = 0; i < 85; i++) begin
      if (i < 5) begin
        alu_op = d_aop[i]; funct7 = d_f7[i]; funct3 = d_f3[i]; valid_i = 1'b1;
      end else begin
        f7_pick = '{7'h00, 7'h20, 7'h01, 7'($urandom_range(0, 127))};
        alu_op  = 3'($urandom_range(0, 7));
        funct7  = f7_pick[$urandom_range(0, 3)];
        funct3  = 3'($urandom_range(0, 7));
        valid_i = 1'($urandom_range(0, 3) != 0);
      end
      valid2   = valid_i;
      rs2_zero = 1'($urandom_range(0, 1));
      #1;
      ref_decode(alu_op, funct7, funct3, 1'b1, code, bad);
      ref_decode(alu_op, funct7, funct3, 1'b0, code2, bad2);
      tests++;
      if (operation !== 5'(code) || illegal !== (valid_i & bad) || stall !== 1'b0) begin
        fails++;
        $display("FAIL decode aop=%0d f7=%h f3=%0d v=%0b: op=%0d ill=%0b stall=%0b, want op=%0d ill=%0b stall=0",
                 alu_op, funct7, funct3, valid_i, operation, illegal, stall, code, valid_i & bad);
      end
      tests++;
      if (operation2 !== 5'(code2) || illegal2 !== (valid2 & bad2)) begin
        fails++;
        $display("FAIL decode_nomd aop=%0d f7=%h f3=%0d: op=%0d ill=%0b, want op=%0d ill=%0b",
                 alu_op, funct7, funct3, operation2, illegal2, code2, valid2 & bad2);
      end
    end
    flush = 1'b0; valid_i = 1'b0; valid2 = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issue one M op whose cycle 0 is the next clock cycle; flush_at < 0 means no flush.
  task automatic run_md(input logic [2:0] f3, input logic rz, input int flush_at);
    int lat;
    logic [2:0] exp;
    lat = (f3[2] && rz) ? 1 : (f3[2] ? DIV_LAT : MUL_LAT);
    @(posedge clk); #1;
    valid_i = 1'b1; flush = 1'b0; alu_op = 3'b010; funct7 = 7'h01; funct3 = f3; rs2_zero = rz;
    #1;
    tests++;
    if (stall !== 1'b1 || md_start !== 1'b0 || md_done !== 1'b0 || operation !== 5'd17) begin
      fails++;
      $display("FAIL md_cycle0 f3=%0d: stall=%0b start=%0b done=%0b op=%0d, want 1/0/0/17",
               f3, stall, md_start, md_done, operation);
    end
    if (flush_at < 0) exp_q.push_back(f3);
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      if (flush_at >= 0 && c == flush_at + 1) begin
        flush = 1'b0; valid_i = 1'b0;
        #1;
        tests++;
        if (fsm_state !== 2'd0 || stall !== 1'b0 || md_start !== 1'b0 || md_done !== 1'b0) begin
          fails++;
          $display("FAIL flush_idle: state=%0d stall=%0b start=%0b done=%0b, want 0/0/0/0",
                   fsm_state, stall, md_start, md_done);
        end
        for (int k = 0; k < 4; k++) begin
          @(posedge clk); #2;
          tests++;
          if (md_done !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_done: md_done=%0b want 0", md_done);
          end
        end
        return;
      end
      #1;
      tests++;
      if (md_start !== (c == 1)) begin
        fails++;
        $display("FAIL md_start f3=%0d cycle %0d: got %0b want %0b", f3, c, md_start, c == 1);
      end
      tests++;
      if (stall !== (c <= lat)) begin
        fails++;
        $display("FAIL stall f3=%0d cycle %0d: got %0b want %0b", f3, c, stall, c <= lat);
      end
      tests++;
      if (md_done !== (c == lat + 1)) begin
        fails++;
        $display("FAIL md_done f3=%0d cycle %0d: got %0b want %0b", f3, c, md_done, c == lat + 1);
      end
      tests++;
      if (operation !== 5'd17) begin
        fails++;
        $display("FAIL md_operation cycle %0d: got %0d want 17", c, operation);
      end
      if (c == lat + 1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL md_op_queue: md_done with no expected op");
        end else begin
          exp = exp_q.pop_front();
          if (md_op !== exp) begin
            fails++;
            $display("FAIL md_op: got %0d want %0d", md_op, exp);
          end
        end
      end
      if (c == flush_at) flush = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    valid_i = 1'b0; flush = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || fsm_state !== 2'd0) begin
      fails++;
      $display("FAIL idle_after_done: stall=%0b state=%0d, want 0/0", stall, fsm_state);
    end
  endtask

  task automatic test_mul();
    run_md(3'b000, 1'b0, -1);
    idle_cycle();
  endtask

  task automatic test_div();
    run_md(3'b101, 1'b1, -1);
    idle_cycle();
    run_md(3'b101, 1'b0, -1);
    idle_cycle();
  endtask

  task automatic test_flush();
    run_md(3'b100, 1'b0, 10);
    run_md(3'b000, 1'b0, -1);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_md(3'b001, 1'b0, -1);
    run_md(3'b111, 1'b1, -1);
    run_md(3'b011, 1'b1, -1);
    idle_cycle();
  endtask

  task automatic test_random_md();
    for (int i = 0; i < 8; i++) begin
      run_md(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) != 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    valid_i = 1'b1; alu_op = 3'b010; funct7 = 7'h01; funct3 = 3'b000; rs2_zero = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    tests++;
    if (fsm_state !== 2'd0 || md_start !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_run: state=%0d start=%0b done=%0b stall=%0b, want all 0",
               fsm_state, md_start, md_done, stall);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      tests++;
      if (md_done !== 1'b0 || md_start !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_done: done=%0b start=%0b want 0/0", md_done, md_start);
      end
    end
  endtask

  task automatic test_md_disabled();
    @(posedge clk); #1;
    valid_i = 1'b0; valid2 = 1'b1; flush = 1'b0;
    alu_op = 3'b010; funct7 = 7'h01; funct3 = 3'b000;
    #1;
    tests++;
    if (illegal2 !== 1'b1 || stall2 !== 1'b0 || operation2 !== 5'd0) begin
      fails++;
      $display("FAIL nomd_md: ill=%0b stall=%0b op=%0d, want 1/0/0", illegal2, stall2, operation2);
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (fsm_state2 !== 2'd0 || md_start2 !== 1'b0 || md_done2 !== 1'b0) begin
      fails++;
      $display("FAIL nomd_idle: state=%0d start=%0b done=%0b, want 0/0/0", fsm_state2, md_start2, md_done2);
    end
    funct7 = 7'h02; valid_i = 1'b1;
    #1;
    tests++;
    if (illegal2 !== 1'b1 || illegal !== 1'b1 || stall !== 1'b0) begin
      fails++;
      $display("FAIL funct7_0000010: ill2=%0b ill=%0b stall=%0b, want 1/1/0", illegal2, illegal, stall);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; valid2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_random_md();
    test_reset_mid_run();
    test_md_disabled();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_ops: %0d expected md_done never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised ALU control unit for the EX stage of the RISC-V core. It decodes ALUOp/funct3/funct7 into a one-hot-free ALU operation code and covers the full RV32I ALU and branch set. It also sequences multi-cycle RV32M multiply/divide operations through an IDLE/RUN/DONE state machine that stalls the pipeline and issues start/done strobes to the mul/div datapath.

## Interface
- OP_W, 5, width of `operation`; must be >= 5
- MUL_LAT, 4, mul/div datapath cycles for MUL/MULH/MULHSU/MULHU (funct3[2]=0); >= 1
- DIV_LAT, 32, datapath cycles for DIV/DIVU/REM/REMU (funct3[2]=1); >= 1
- MD_EN, 1, 1 = RV32M supported; 0 = funct7 0000001 is illegal

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_i  in  1  EX holds a valid instruction
- flush  in  1  kill EX instruction (branch/trap)
- alu_op  in  3  000 LW/SW/AUIPC, 001 branch, 010 R-type, 011 I-type ALU, 100 JAL/LUI; 101-111 reserved
- funct7  in  7  instr[31:25]
- funct3  in  3  instr[14:12]
- rs2_zero  in  1  rs2 operand == 0 (divide-by-zero fast path)
- operation  out  OP_W  ALU operation code, zero-extended
- md_start  out  1  one-cycle start strobe to mul/div datapath
- md_op  out  3  latched funct3 of the running M op
- md_done  out  1  one-cycle result-valid strobe (write-back enable)
- stall  out  1  hold IF/ID/EX
- illegal  out  1  unsupported encoding in EX

## Operation
- Codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15, PASSB 16, MD 17.
- alu_op 000 -> ADD. 100 -> PASSB. 001 -> branch code by funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal).
- 010 R-type: funct7 0000000 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7 0100000 with funct3 000 -> SUB, with 101 -> SRA, other funct3 illegal. funct7 0000001 -> MD (illegal if MD_EN=0). Any other funct7 is illegal.
- 011 I-type: same as funct7=0000000 row, funct7 ignored, except for the following. funct3 001 requires funct7 0000000. funct3 101 with 0000000 -> SRL, with 0100000 -> SRA, otherwise illegal. No SUB.
- alu_op 101-111 -> illegal.
- `illegal` = valid_i & bad encoding, combinational. `operation` = ADD whenever illegal. Illegal never starts the FSM.
- FSM states:
  - IDLE: accept when valid_i & ~flush & MD decode & ~illegal. On accept, latch md_op=funct3. Load cnt = 0 if funct3[2] & rs2_zero, else LAT-1. Go RUN.
  - RUN: cnt decrements each cycle. At cnt==0 go DONE.
  - DONE: return to IDLE unconditionally. The still-present instruction is not re-accepted.
- md_start is registered: high exactly the first RUN cycle.
- md_done is registered: high exactly the DONE cycle.
- cnt width is $clog2(max(MUL_LAT,DIV_LAT)+1). No wrap: decrement only when cnt != 0.
- flush in RUN or DONE: next state IDLE, cnt=0, md_start/md_done low next cycle. No md_done for the killed op.
- flush in IDLE suppresses accept.
- operation = MD in RUN/DONE, independent of inputs.

## Timing
- Reset (async): state IDLE, cnt 0, md_op 000, md_start 0, md_done 0. operation/stall/illegal follow their combinational decode of inputs; stall=0 in IDLE without accept.
- Decode outputs are combinational, zero latency.
- stall = (IDLE & accept) | RUN, combinational. It is low in DONE.
- With accept at cycle 0: stall is high for cycles 0..LAT, and md_done is high at cycle LAT+1. The pipeline advances at the end of cycle LAT+1.
- Divide by zero: stall for cycles 0..1, md_done at cycle 2.
- Back-to-back M ops: the second is accepted the cycle after DONE (IDLE). There is no bubble beyond DONE.
- Reset asserted mid-RUN: IDLE immediately, strobes low, no md_done.

## Test plan
- Reset with alu_op=010/funct7=0000001/valid_i=1 held -> state IDLE, md_start=md_done=0. After release, accept occurs on the first edge.
- Decode sweep: 010/0100000/000 -> 1 (SUB); 011/0100000/101 -> 7 (SRAI); 011/0000001/000 -> 0 (ADDI, funct7 ignored); 001/xxx/110 -> 14; 001/xxx/010 -> illegal=1, operation=0.
- MUL, MUL_LAT=4, accept at cycle 0 -> stall=1 cycles 0-4, md_start at cycle 1, md_done at cycle 5 with md_op=000, stall=0 at cycle 5.
- DIVU (funct3 101) with rs2_zero=1 -> md_start at cycle 1, md_done at cycle 2. With rs2_zero=0 and DIV_LAT=32 -> md_done at cycle 33.
- DIV accepted, flush at cycle 10 -> IDLE at cycle 11, stall=0, md_done never asserted. The next valid MUL is accepted normally.
- MD_EN=0, R-type funct7 0000001 -> illegal=1, stall=0, FSM stays IDLE. Also check funct7 0000010 -> illegal=1.
